// File: rtl/button_toggle_bank.sv
// Multi-channel button debouncer with per-channel toggle/momentary LED drive,
// one-cycle press pulses and a global clear for toggle-mode LEDs.
module button_toggle_bank #(
  parameter int CHANNELS        = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button,
  input  logic [CHANNELS-1:0] mode,
  input  logic                clear,
  output logic [CHANNELS-1:0] led,
  output logic [CHANNELS-1:0] press_pulse
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CHANNELS-1:0] db;
  logic [CW-1:0]       cnt [CHANNELS];

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic differs;
    logic accept;
    logic db_next;

    // A change is accepted on the edge that sees the DEBOUNCE_CYCLES-th differing sample.
    always_comb begin
      differs = (button[i] != db[i]);
      accept  = differs && (cnt[i] == CNT_LAST);
      db_next = accept ? button[i] : db[i];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        db[i]          <= 1'b0;
        cnt[i]         <= '0;
        led[i]         <= 1'b0;
        press_pulse[i] <= 1'b0;
      end else begin
        db[i]          <= db_next;
        press_pulse[i] <= accept && button[i];
        if (!differs || accept)
          cnt[i] <= '0;
        else
          cnt[i] <= cnt[i] + 1'b1;

        // Momentary follows the debounced level; toggle honours clear before a press.
        if (mode[i])
          led[i] <= db_next;
        else if (clear)
          led[i] <= 1'b0;
        else if (accept && button[i])
          led[i] <= ~led[i];
      end
    end
  end

endmodule

// File: tb/tb_button_toggle_bank.sv
// Self-checking bench for button_toggle_bank: directed scenarios plus randomized
// stimulus compared every cycle against a behavioural per-channel model.
module tb_button_toggle_bank;

  localparam int CH = 4;
  localparam int DB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] button = '0;
  logic [CH-1:0] mode = '0;
  logic          clear = 1'b0;
  logic [CH-1:0] led;
  logic [CH-1:0] press_pulse;

  int checks = 0;
  int errors = 0;

  logic [CH-1:0] m_db, m_led, m_pulse;
  int            m_run [CH];

  button_toggle_bank #(.CHANNELS(CH), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .button(button), .mode(mode), .clear(clear),
    .led(led), .press_pulse(press_pulse)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: count consecutive samples that disagree with the accepted level.
  task automatic modelStep();
    logic acc;
    if (reset) begin
      m_db = '0; m_led = '0; m_pulse = '0;
      for (int i = 0; i < CH; i++) m_run[i] = 0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        acc = 1'b0;
        if (button[i] != m_db[i]) begin
          m_run[i] = m_run[i] + 1;
          if (m_run[i] == DB) begin
            m_db[i] = button[i];
            m_run[i] = 0;
            acc = 1'b1;
          end
        end else begin
          m_run[i] = 0;
        end
        m_pulse[i] = acc && m_db[i];
        if (mode[i]) m_led[i] = m_db[i];
        else if (clear) m_led[i] = 1'b0;
        else if (acc && m_db[i]) m_led[i] = ~m_led[i];
      end
    end
  endtask

  task automatic applyStimulus(input logic [CH-1:0] b, input logic [CH-1:0] m,
                               input logic c, input logic r);
    @(negedge clk);
    button = b; mode = m; clear = c; reset = r;
    @(posedge clk);
    modelStep();
    #1;
    checkOutput("led", 32'(led), 32'(m_led));
    checkOutput("pulse", 32'(press_pulse), 32'(m_pulse));
  endtask

  initial begin
    logic [7:0] bounce;
    logic [CH-1:0] rb, rm;
    logic rc, rr;

    m_db = '0; m_led = '0; m_pulse = '0;
    for (int i = 0; i < CH; i++) m_run[i] = 0;

    // Reset held with all buttons pressed, then the press lands on the 4th edge
    for (int k = 0; k < 5; k++) applyStimulus(4'hF, 4'h0, 1'b0, 1'b1);
    checkOutput("reset_led", 32'(led), 32'h0);
    for (int k = 0; k < 3; k++) applyStimulus(4'hF, 4'h0, 1'b0, 1'b0);
    checkOutput("latency_led_early", 32'(led), 32'h0);
    applyStimulus(4'hF, 4'h0, 1'b0, 1'b0);
    checkOutput("latency_led", 32'(led), 32'hF);
    checkOutput("latency_pulse", 32'(press_pulse), 32'hF);
    applyStimulus(4'hF, 4'h0, 1'b0, 1'b0);
    checkOutput("pulse_one_cycle", 32'(press_pulse), 32'h0);

    // Toggle sequence on channel 0
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++) applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("toggle_hold", 32'(led), 32'h1);
    for (int k = 0; k < 6; k++) applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    checkOutput("toggle_off", 32'(led), 32'h0);
    for (int k = 0; k < 6; k++) applyStimulus(4'h0, 4'h0, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    checkOutput("toggle_on", 32'(led), 32'h1);

    // Bounce on channel 1 is rejected, then a clean hold is accepted
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1);
    bounce = 8'b01110111;
    for (int k = 0; k < 8; k++) applyStimulus({2'b00, bounce[k], 1'b0}, 4'h0, 1'b0, 1'b0);
    checkOutput("bounce_led", 32'(led), 32'h0);
    for (int k = 0; k < 4; k++) applyStimulus(4'h2, 4'h0, 1'b0, 1'b0);
    checkOutput("bounce_hold", 32'(led), 32'h2);

    // Momentary channel 2 ignores clear
    applyStimulus(4'h0, 4'h4, 1'b0, 1'b1);
    for (int k = 0; k < 6; k++) applyStimulus(4'h4, 4'h4, 1'b1, 1'b0);
    checkOutput("momentary_on", 32'(led), 32'h4);
    for (int k = 0; k < 4; k++) applyStimulus(4'h0, 4'h4, 1'b0, 1'b0);
    checkOutput("momentary_off", 32'(led), 32'h0);

    // Clear on the same edge as an accepted press on channel 3
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) applyStimulus(4'h3, 4'h0, 1'b0, 1'b0);
    checkOutput("pre_clear_led", 32'(led), 32'h3);
    for (int k = 0; k < 3; k++) applyStimulus(4'hB, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'hB, 4'h0, 1'b1, 1'b0);
    checkOutput("clear_press_led", 32'(led), 32'h0);
    checkOutput("clear_press_pulse", 32'(press_pulse), 32'h8);

    // Reset mid-count restarts the debounce
    applyStimulus(4'h0, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 2; k++) applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    checkOutput("midreset_early", 32'(led), 32'h0);
    applyStimulus(4'h1, 4'h0, 1'b0, 1'b0);
    checkOutput("midreset_led", 32'(led), 32'h1);

    // Randomized traffic: slow-changing buttons, occasional mode flips, clear and reset
    rb = '0; rm = '0;
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++) begin
        if ($urandom_range(0, 5) == 0) rb[i] = ~rb[i];
        if ($urandom_range(0, 60) == 0) rm[i] = ~rm[i];
      end
      rc = ($urandom_range(0, 12) == 0);
      rr = ($urandom_range(0, 300) == 0);
      applyStimulus(rb, rm, rc, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
